soc_new_cpu_debug_action_sequencer: RTL
=======================================

SOC_NEW_CPU_DEBUG_ACTION_SEQUENCER -- requirements
Module: soc_new_cpu_debug_action_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of cycles to wait for mem_ack.
REQ-003 SHALL have parameter ADDR_W, default 8, the OCI memory word-address width.
REQ-004 SHALL have ports in this order:
- clk  in  1  single clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- jdo  in  38  JTAG command payload, valid in the cycle of any take_action strobe.
- take_action_ocimem_a  in  1  set-address strobe.
- take_action_ocimem_b  in  1  memory-access strobe.
- take_action_tracemem_a  in  1  trace-address strobe.
- take_action_tracemem_b  in  1  trace-read strobe.
- mem_req  out  1  OCI memory request.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- mem_ack  in  1  access complete.
- mem_rdata  in  32  read data, valid with mem_ack.
- trc_req  out  1  trace read request.
- trc_addr  out  7  trace address.
- trc_ack  in  1  trace read complete.
- trc_rdata  in  36  trace data, valid with trc_ack.
- MonDReg  out  32  monitor data register.
- monitor_ready  out  1  last command finished.
- monitor_error  out  1  last command timed out or was dropped.
- busy  out  1  FIFO not empty or FSM not IDLE.

Function
REQ-005 SHALL push one FIFO entry {opcode[1:0], jdo} per cycle on any strobe, with priority ocimem_a > ocimem_b > tracemem_a > tracemem_b when strobes coincide; lower-priority strobes in that cycle are dropped and set monitor_error.
REQ-006 SHALL drop a strobe arriving while the FIFO is full, set monitor_error, and leave the FIFO contents unchanged.
REQ-007 SHALL use FSM states IDLE, DECODE, MEM_WAIT, TRC_WAIT and DONE.
- IDLE -> DECODE when the FIFO is non-empty; the FIFO is popped in the same cycle.
- DECODE, ocimem_a: load addr_reg = jdo[ADDR_W+25:26] and autoinc = jdo[34], then go to DONE.
- DECODE, ocimem_b: assert mem_req, with mem_we = jdo[37] and mem_wdata = jdo[31:0], then go to MEM_WAIT.
- DECODE, tracemem_a: load trc_addr = jdo[6:0], then go to DONE.
- DECODE, tracemem_b: assert trc_req, then go to TRC_WAIT.
REQ-008 SHALL hold mem_req and its address/data stable in MEM_WAIT until mem_ack; on ack, MonDReg = mem_rdata for reads (unchanged for writes), then go to DONE.
REQ-009 SHALL on trc_ack in TRC_WAIT set MonDReg = trc_rdata[31:0], increment trc_addr modulo 128 (127 wraps to 0), then go to DONE.
REQ-010 SHALL count wait cycles in MEM_WAIT and TRC_WAIT; reaching TIMEOUT_CYCLES deasserts the request, sets monitor_error, leaves MonDReg unchanged, and goes to DONE.
REQ-011 SHALL increment addr_reg modulo 2^ADDR_W after each completed or timed-out ocimem_b access when autoinc = 1.
REQ-012 SHALL in DONE pulse monitor_ready for 1 cycle, then return to IDLE; the minimum strobe-to-monitor_ready latency is 3 cycles for non-memory opcodes.
REQ-013 SHALL clear monitor_error on the next accepted strobe that does not itself error.
REQ-014 SHALL ignore an ack arriving outside its WAIT state.

Reset
REQ-015 SHALL on reset_n low asynchronously:
- empty the FIFO and set the FSM to IDLE;
- set addr_reg, autoinc, trc_addr, MonDReg and the timeout counter to 0;
- drive mem_req, mem_we, trc_req, monitor_ready, monitor_error and busy to 0.
REQ-016 SHALL abandon any in-flight access when reset asserts mid-operation, without issuing another request.

Configuration
REQ-017 SHALL, with macro SOC_NEW_DEBUG_SEQ_TRACE_EN defined, implement the tracemem opcodes as above.
REQ-018 SHALL, without SOC_NEW_DEBUG_SEQ_TRACE_EN:
- discard tracemem strobes without pushing them and without setting monitor_error;
- tie trc_req to 0 and trc_addr to 0;
- omit the TRC_WAIT state.

Structure
REQ-019 SHALL place the opcode enum, the FSM state enum, and FIFO entry width constant 40 in package soc_new_cpu_debug_pkg.
REQ-020 SHALL implement the FIFO as sub-module soc_new_cpu_debug_cmd_fifo (push, pop, full, empty, count).

Verification
REQ-021 SHALL cover these directed scenarios:
- ocimem_a with jdo[33:26]=0x10 and jdo[34]=1, then three ocimem_b reads with mem_ack after 2 cycles -> mem_addr 0x10, 0x11, 0x12 and three monitor_ready pulses.
- ocimem_b with jdo[37]=1 and jdo[31:0]=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF held until ack; MonDReg unchanged.
- mem_ack withheld -> mem_req drops after exactly 255 cycles, monitor_error=1, monitor_ready pulses.
- 5 strobes back-to-back while mem_ack is stalled -> 4 accepted, 5th sets monitor_error; the 4 accepted are serviced in order.
- tracemem_a with jdo[6:0]=127, then tracemem_b with trc_rdata=0x5_12345678 -> MonDReg=0x12345678, trc_addr=0; with the macro undefined -> no trc_req.
- reset_n low during MEM_WAIT -> all outputs 0 immediately; busy=0 after release.

Source files
------------

// File: rtl/soc_new_cpu_debug_pkg.sv
// Shared types for the CPU debug action sequencer.
// SOC_NEW_DEBUG_SEQ_TRACE_EN adds the TRC_WAIT state for trace reads.
package soc_new_cpu_debug_pkg;

    localparam int ENTRY_W = 40;

    typedef enum logic [1:0] {
        OP_OCIMEM_A   = 2'd0,
        OP_OCIMEM_B   = 2'd1,
        OP_TRACEMEM_A = 2'd2,
        OP_TRACEMEM_B = 2'd3
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DECODE   = 3'd1,
        MEM_WAIT = 3'd2,
`ifdef SOC_NEW_DEBUG_SEQ_TRACE_EN
        TRC_WAIT = 3'd3,
`endif
        DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/soc_new_cpu_debug_cmd_fifo.sv
// Command FIFO for the debug action sequencer.
// Pushes while full and pops while empty are ignored.
module soc_new_cpu_debug_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = count == FULL_CNT;
    assign empty    = count == '0;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/soc_new_cpu_debug_action_sequencer.sv
// Queues JTAG debug actions and sequences OCI memory / trace accesses.
// Trace opcodes exist only with SOC_NEW_DEBUG_SEQ_TRACE_EN defined.
module soc_new_cpu_debug_action_sequencer
    import soc_new_cpu_debug_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_action_tracemem_a,
    input  logic              take_action_tracemem_b,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              trc_req,
    output logic [6:0]        trc_addr,
    input  logic              trc_ack,
    input  logic [35:0]       trc_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                     state, state_d;
    opcode_e                    push_op, cur_op;
    logic [ENTRY_W-1:0]         fifo_dout, cur_cmd;
    logic                       fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                       stb_ta, stb_tb, any_stb, multi_stb, stb_err;
    logic [3:0]                 stb_vec;
    logic [CNT_W-1:0]           tmo_cnt;
    logic                       in_mem, in_trc, cnt_end, tmo_evt;
    logic                       mem_hit, trc_hit;
    logic [ADDR_W-1:0]          addr_reg;
    logic                       autoinc;
    logic                       unused_sink;

`ifdef SOC_NEW_DEBUG_SEQ_TRACE_EN
    assign stb_ta = take_action_tracemem_a;
    assign stb_tb = take_action_tracemem_b;
    assign in_trc = state == TRC_WAIT;
`else
    assign stb_ta = 1'b0;
    assign stb_tb = 1'b0;
    assign in_trc = 1'b0;
`endif

    assign stb_vec   = {stb_tb, stb_ta, take_action_ocimem_b, take_action_ocimem_a};
    assign any_stb   = |stb_vec;
    assign multi_stb = (stb_vec & (stb_vec - 4'd1)) != 4'd0;
    assign stb_err   = multi_stb || (any_stb && fifo_full);
    assign cur_op    = opcode_e'(cur_cmd[39:38]);
    assign in_mem    = state == MEM_WAIT;
    assign mem_hit   = in_mem && mem_ack;
    assign trc_hit   = in_trc && trc_ack;
    assign cnt_end   = tmo_cnt == CNT_LAST;
    assign tmo_evt   = ((in_mem && !mem_ack) || (in_trc && !trc_ack)) && cnt_end;

    assign mem_addr      = addr_reg;
    assign monitor_ready = state == DONE;
    assign busy          = !fifo_empty || (state != IDLE);
    assign unused_sink   = ^{cur_cmd, trc_rdata, trc_ack, fifo_count,
                             take_action_tracemem_a, take_action_tracemem_b};

    // Highest-priority strobe selects the opcode that is queued.
    always_comb begin
        push_op = OP_OCIMEM_A;
        priority case (1'b1)
            take_action_ocimem_a: push_op = OP_OCIMEM_A;
            take_action_ocimem_b: push_op = OP_OCIMEM_B;
            stb_ta:               push_op = OP_TRACEMEM_A;
            default:              push_op = OP_TRACEMEM_B;
        endcase
    end

    soc_new_cpu_debug_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (any_stb),
        .push_data ({push_op, jdo}),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Next-state logic; popping happens on the IDLE->DECODE step.
    always_comb begin
        state_d  = state;
        fifo_pop = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                unique case (cur_op)
                    OP_OCIMEM_B:   state_d = MEM_WAIT;
`ifdef SOC_NEW_DEBUG_SEQ_TRACE_EN
                    OP_TRACEMEM_B: state_d = TRC_WAIT;
`endif
                    default:       state_d = DONE;
                endcase
            end
            MEM_WAIT: if (mem_ack || cnt_end) state_d = DONE;
`ifdef SOC_NEW_DEBUG_SEQ_TRACE_EN
            TRC_WAIT: if (trc_ack || cnt_end) state_d = DONE;
`endif
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Wait-cycle counter, cleared whenever a wait state is left.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                              tmo_cnt <= '0;
        else if ((in_mem || in_trc) && state_d == state) tmo_cnt <= tmo_cnt + CNT_W'(1);
        else                                       tmo_cnt <= '0;
    end

    // Sticky error: set by drops/timeouts, cleared by a clean strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                monitor_error <= 1'b0;
        else if (tmo_evt || stb_err) monitor_error <= 1'b1;
        else if (any_stb)            monitor_error <= 1'b0;
    end

    // Command latch, OCI memory request and monitor data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_cmd   <= '0;
            addr_reg  <= '0;
            autoinc   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            MonDReg   <= '0;
        end else begin
            if (fifo_pop) cur_cmd <= fifo_dout;
            if (state == DECODE && cur_op == OP_OCIMEM_A) begin
                addr_reg <= cur_cmd[ADDR_W+25:26];
                autoinc  <= cur_cmd[34];
            end
            if (state == DECODE && cur_op == OP_OCIMEM_B) begin
                mem_req   <= 1'b1;
                mem_we    <= cur_cmd[37];
                mem_wdata <= cur_cmd[31:0];
            end
            if (in_mem && (mem_ack || cnt_end)) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (autoinc) addr_reg <= addr_reg + ADDR_W'(1);
            end
            if (mem_hit && !mem_we) MonDReg <= mem_rdata;
            if (trc_hit)            MonDReg <= trc_rdata[31:0];
        end
    end

`ifdef SOC_NEW_DEBUG_SEQ_TRACE_EN
    // Trace address pointer and trace read request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trc_addr <= '0;
            trc_req  <= 1'b0;
        end else begin
            if (state == DECODE && cur_op == OP_TRACEMEM_A) trc_addr <= cur_cmd[6:0];
            if (state == DECODE && cur_op == OP_TRACEMEM_B) trc_req  <= 1'b1;
            if (in_trc && (trc_ack || cnt_end))             trc_req  <= 1'b0;
            if (trc_hit)                                    trc_addr <= trc_addr + 7'd1;
        end
    end
`else
    assign trc_addr = '0;
    assign trc_req  = 1'b0;
`endif

endmodule
